xor_load_sequencer: RTL and testbench

XOR_LOAD_SEQUENCER -- requirements
Module: xor_load_sequencer

---
 rtl/xor_load_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_xor_load_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/xor_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : xor_load_sequencer
// Purpose  : Streams a load frame of KEY_BYTES key bytes followed by
//            MSG_BYTES message bytes to a bit-serial cipher. Each byte is
//            accepted over a valid/ready handshake and shifted out MSB first,
//            one bit per cycle, tagged with load_key or load_msg.
// Ports    : clk, rst_n (async, active-low)
//            ena        - global enable, low freezes all state
//            start      - begin a frame (ignored while busy)
//            abort      - drop the current frame and return to idle
//            in_data    - host byte, in_valid / in_ready handshake
//            serial_out - serial bit to the cipher
//            load_key   - serial_out carries a key bit this cycle
//            load_msg   - serial_out carries a message bit this cycle
//            busy       - frame in progress
//            done       - one-cycle pulse at frame completion
// Revision : 1.0 - initial release
// ============================================================================
module xor_load_sequencer #(
    parameter int KEY_BYTES = 4,
    parameter int MSG_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       serial_out,
    output logic       load_key,
    output logic       load_msg,
    output logic       busy,
    output logic       done
);

    localparam int c_total_bytes = KEY_BYTES + MSG_BYTES;
    localparam int c_cnt_w       = $clog2(c_total_bytes + 1);

    localparam logic [c_cnt_w-1:0] c_key_cnt   = c_cnt_w'(KEY_BYTES);
    localparam logic [c_cnt_w-1:0] c_total_cnt = c_cnt_w'(c_total_bytes);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_key  = 2'd1;
    localparam logic [1:0] c_st_msg  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_byte_cnt;   // bytes accepted in this frame
    logic [2:0]         r_bit_idx;    // index of the bit now on serial_out
    logic               r_sr_full;    // shift register holds a live bit
    logic               r_sr_key;     // live byte belongs to the key
    logic [7:0]         r_shreg;      // MSB is the bit on serial_out
    logic               r_in_ready;
    logic               r_load_key;
    logic               r_load_msg;
    logic               r_busy;
    logic               r_done;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic [1:0]         w_state;
    logic [c_cnt_w-1:0] w_byte_cnt;
    logic [2:0]         w_bit_idx;
    logic               w_sr_full;
    logic               w_sr_key;
    logic [7:0]         w_shreg;
    logic               w_xfer;
    logic               w_last_bit;
    logic               w_in_ready;
    logic               w_load_key;
    logic               w_load_msg;
    logic               w_busy;
    logic               w_done;

    always_comb begin
        w_state    = r_state;
        w_byte_cnt = r_byte_cnt;
        w_bit_idx  = r_bit_idx;
        w_sr_full  = r_sr_full;
        w_sr_key   = r_sr_key;
        w_shreg    = r_shreg;
        // ena is applied by the register enable and the output gating,
        // so here only the registered ready and the host valid matter.
        w_xfer     = in_valid & r_in_ready;
        w_last_bit = r_sr_full & (r_bit_idx == 3'd7);

        if (abort) begin
            w_state    = c_st_idle;
            w_byte_cnt = '0;
            w_bit_idx  = 3'd0;
            w_sr_full  = 1'b0;
            w_sr_key   = 1'b0;
            w_shreg    = 8'h00;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        w_state    = c_st_key;
                        w_byte_cnt = '0;
                        w_bit_idx  = 3'd0;
                        w_sr_full  = 1'b0;
                        w_sr_key   = 1'b0;
                        w_shreg    = 8'h00;
                    end
                end
                c_st_key, c_st_msg: begin
                    if (w_xfer) begin
                        w_shreg    = in_data;
                        w_bit_idx  = 3'd0;
                        w_sr_full  = 1'b1;
                        w_sr_key   = (r_byte_cnt < c_key_cnt);
                        w_byte_cnt = r_byte_cnt + 1'b1;
                    end else if (r_sr_full) begin
                        if (r_bit_idx == 3'd7) begin
                            // Drained with no byte waiting: hold the index
                            // at 7 and present zeros until the host resumes.
                            w_sr_full = 1'b0;
                            w_shreg   = 8'h00;
                        end else begin
                            w_shreg   = {r_shreg[6:0], 1'b0};
                            w_bit_idx = r_bit_idx + 3'd1;
                        end
                    end
                    // The byte in flight is the final one of its phase when
                    // the accepted count already equals the phase boundary;
                    // no newer byte can be accepted before its bit 7.
                    if (r_state == c_st_key && w_last_bit && r_byte_cnt == c_key_cnt) begin
                        w_state = c_st_msg;
                    end
                    if (r_state == c_st_msg && w_last_bit && r_byte_cnt == c_total_cnt) begin
                        w_state = c_st_done;
                    end
                end
                c_st_done: begin
                    w_state = c_st_idle;
                end
                default: begin
                    w_state = c_st_idle;
                end
            endcase
        end

        // Outputs are registered from the next-state values.
        w_in_ready = ((w_state == c_st_key) || (w_state == c_st_msg)) &&
                     (!w_sr_full || (w_bit_idx == 3'd7)) &&
                     (w_byte_cnt != c_total_cnt);
        w_load_key = w_sr_full & w_sr_key;
        w_load_msg = w_sr_full & ~w_sr_key;
        w_busy     = (w_state != c_st_idle);
        w_done     = (w_state == c_st_done);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_byte_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_sr_full  <= 1'b0;
            r_sr_key   <= 1'b0;
            r_shreg    <= 8'h00;
            r_in_ready <= 1'b0;
            r_load_key <= 1'b0;
            r_load_msg <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (ena) begin
            r_state    <= w_state;
            r_byte_cnt <= w_byte_cnt;
            r_bit_idx  <= w_bit_idx;
            r_sr_full  <= w_sr_full;
            r_sr_key   <= w_sr_key;
            r_shreg    <= w_shreg;
            r_in_ready <= w_in_ready;
            r_load_key <= w_load_key;
            r_load_msg <= w_load_msg;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    // While ena is low the held bit is not delivered: the handshake and
    // load flags are masked in the same cycle, and the identical bit is
    // presented again with its flag once ena returns.
    assign serial_out = r_shreg[7];
    assign in_ready   = r_in_ready & ena;
    assign load_key   = r_load_key & ena;
    assign load_msg   = r_load_msg & ena;
    assign done       = r_done & ena;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_xor_load_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_xor_load_sequencer
// Purpose  : Self-checking bench for xor_load_sequencer. A table of frame
//            scenarios (host stall, enable freeze, abort, start while busy)
//            is replayed cycle by cycle against a host model; a hand-written
//            sequence covers reset at power-up and reset mid-frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xor_load_sequencer;

    localparam int KB      = 4;
    localparam int MB      = 64;
    localparam int NB      = KB + MB;
    localparam int RUN_CYC = 600;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ena      = 1'b0;
    logic       start    = 1'b0;
    logic       abort    = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       serial_out;
    logic       load_key;
    logic       load_msg;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    xor_load_sequencer #(
        .KEY_BYTES (KB),
        .MSG_BYTES (MB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .serial_out (serial_out),
        .load_key   (load_key),
        .load_msg   (load_msg),
        .busy       (busy),
        .done       (done)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] frame_bytes [NB];
    logic [7:0] first8;

    // Scenario knobs first, then hand-computed expectations (cycle 0 is
    // the cycle in which start is high; -1 means "not expected").
    typedef struct {
        int stall_byte;   // host withholds this byte index ...
        int stall_len;    // ... for this many cycles of in_ready high
        int ena_at;       // first cycle with ena low
        int ena_len;      // number of cycles with ena low
        int restart_at;   // cycle of an extra start while busy
        int abort_at;     // cycle with abort high
        int e_first_key;
        int e_last_key;
        int e_first_msg;
        int e_last_msg;
        int e_done_cyc;
        int e_idle_cyc;
        int e_key_bits;
        int e_msg_bits;
        int e_dones;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input int byte_idx, input int bit_in_byte);
        logic [7:0] b;
        b = frame_bytes[byte_idx];
        return b[7 - bit_in_byte];
    endfunction

    function automatic int outs_packed();
        return int'({serial_out, load_key, load_msg, in_ready, busy, done});
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int hp, stall, kb, mb, dn, bit_err, ovl, gate;
        int fk, lk, fm, lm, dc, ic, rdy0, after_abort;
        logic [7:0] f8;
        hp = 0; stall = v.stall_len; kb = 0; mb = 0; dn = 0;
        bit_err = 0; ovl = 0; gate = 0;
        fk = -1; lk = -1; fm = -1; lm = -1; dc = -1; ic = -1;
        rdy0 = -1; after_abort = -1; f8 = 8'h00;
        for (int c = 0; c < RUN_CYC; c++) begin
            @(negedge clk);
            start = (c == 0) || (c == v.restart_at);
            abort = (c == v.abort_at);
            ena   = !((c >= v.ena_at) && (c < v.ena_at + v.ena_len));
            #1;
            if (hp >= NB) begin
                in_valid = 1'b0;
            end else if (hp == v.stall_byte && stall > 0) begin
                in_valid = 1'b0;
                if (in_ready) stall--;
            end else begin
                in_valid = 1'b1;
                in_data  = frame_bytes[hp];
            end
            #1;
            if (c == 0) rdy0 = int'(in_ready);
            if (c == v.abort_at + 1) after_abort = outs_packed();
            if (load_key && load_msg) ovl++;
            if (!ena && (in_ready || load_key || load_msg || done)) gate++;
            if (load_key) begin
                if (fk < 0) fk = c;
                lk = c;
                if (kb < 8) f8 = {f8[6:0], serial_out};
                if (kb >= KB * 8 || serial_out !== exp_bit(kb / 8, kb % 8)) bit_err++;
                kb++;
            end
            if (load_msg) begin
                if (fm < 0) fm = c;
                lm = c;
                if (mb >= MB * 8 || serial_out !== exp_bit(KB + mb / 8, mb % 8)) bit_err++;
                mb++;
            end
            if (done) begin
                if (dc < 0) dc = c;
                dn++;
            end
            if (c > 0 && !busy && ic < 0) ic = c;
            if (in_valid && in_ready && ena) hp++;
        end
        first8 = f8;
        check($sformatf("v%0d ready_on_start", id), rdy0, 0);
        check($sformatf("v%0d first_key", id), fk, v.e_first_key);
        check($sformatf("v%0d last_key", id), lk, v.e_last_key);
        check($sformatf("v%0d first_msg", id), fm, v.e_first_msg);
        check($sformatf("v%0d last_msg", id), lm, v.e_last_msg);
        check($sformatf("v%0d done_cycle", id), dc, v.e_done_cyc);
        check($sformatf("v%0d idle_cycle", id), ic, v.e_idle_cyc);
        check($sformatf("v%0d key_bits", id), kb, v.e_key_bits);
        check($sformatf("v%0d msg_bits", id), mb, v.e_msg_bits);
        check($sformatf("v%0d done_count", id), dn, v.e_dones);
        check($sformatf("v%0d bit_errors", id), bit_err, 0);
        check($sformatf("v%0d flag_overlap", id), ovl, 0);
        check($sformatf("v%0d ena_gating", id), gate, 0);
        if (v.abort_at >= 0) check($sformatf("v%0d outs_after_abort", id), after_abort, 0);
    endtask

    initial begin
        frame_bytes[0] = 8'hA5;
        frame_bytes[1] = 8'h3C;
        frame_bytes[2] = 8'h0F;
        frame_bytes[3] = 8'h96;
        for (int i = 0; i < MB; i++) frame_bytes[KB + i] = 8'((i * 37 + 11) & 255);

        //          stall  ena    rst  abort  fk lk  fm  lm   done idle kbit mbit dn
        vecs[0] = '{-1, 0, -1, 0, -1, -1,   2, 33, 34, 545, 546, 547, 32, 512, 1};
        vecs[1] = '{ 3, 5, -1, 0, -1, -1,   2, 38, 39, 550, 551, 552, 32, 512, 1};
        vecs[2] = '{-1, 0,  5, 3, -1, -1,   2, 36, 37, 548, 549, 550, 32, 512, 1};
        vecs[3] = '{-1, 0, -1, 0, -1, 117,  2, 33, 34, 117,  -1, 118, 32,  84, 0};
        vecs[4] = '{-1, 0, -1, 0, 100, -1,  2, 33, 34, 545, 546, 547, 32, 512, 1};

        // Reset held with activity on the inputs: everything stays quiet.
        start    = 1'b1;
        in_valid = 1'b1;
        ena      = 1'b1;
        #12;
        check("reset_state", outs_packed(), 0);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
            if (i == 0) check("first_key_byte_bits", int'(first8), 'hA5);
        end

        // Reset asserted mid-frame, then no activity until a new start.
        begin
            int act;
            int mid_msg;
            act = 0;
            @(negedge clk);
            start = 1'b1; abort = 1'b0; ena = 1'b1;
            in_valid = 1'b1; in_data = 8'hC3;
            for (int c = 1; c < 50; c++) begin
                @(negedge clk);
                start = 1'b0;
            end
            #1;
            mid_msg = int'(load_msg && busy);
            check("mid_frame_before_reset", mid_msg, 1);
            rst_n = 1'b0;
            #1;
            check("outs_at_reset", outs_packed(), 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                #1;
                if (outs_packed() != 0) act++;
            end
            check("quiet_after_reset", act, 0);
        end

        run_vec(5, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
